// File: rtl/mdu_pkg.sv
// =============================================================================
// Module      : mdu_pkg
// Description : Shared encodings, FSM states and constants for mult_div_unit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int          MDU_ITER    = 32;
    localparam logic [31:0] MDU_DIVZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_core.sv
// =============================================================================
// Module      : mdu_core
// Description : Iterative shift-add multiplier / restoring divider with sign fix.
//               Divider datapath present only when MDU_DIV_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mdu_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_opa,
    input  logic [31:0] i_opb,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic        r_neg_lo;

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [63:0] w_prod_fix;

`ifdef MDU_DIV_EN
    logic        r_is_div;
    logic        r_neg_hi;
    logic        r_divz;
    logic        w_ge;
    logic [31:0] w_diff;

    assign w_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
    // Remainder stays below the divisor, so a 32-bit difference is exact when w_ge.
    assign w_ge     = r_acc[63:31] >= {1'b0, r_opnd};
    assign w_diff   = r_acc[62:31] - r_opnd;
`else
    assign w_signed = (i_op == MDU_MULT);
`endif

    assign w_a_neg    = w_signed & i_opa[31];
    assign w_b_neg    = w_signed & i_opb[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - i_opa) : i_opa;
    assign w_b_mag    = w_b_neg ? (32'd0 - i_opb) : i_opb;
    assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_prod_fix = r_neg_lo ? (64'd0 - r_acc) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_lo <= 1'b0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_hi <= 1'b0;
            r_divz   <= 1'b0;
`endif
        end else if (i_load) begin
            r_neg_lo <= w_a_neg ^ w_b_neg;
`ifdef MDU_DIV_EN
            r_is_div <= op_is_div(i_op);
            r_neg_hi <= op_is_div(i_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_divz   <= op_is_div(i_op) && (i_opb == 32'd0);
            r_acc    <= {32'd0, op_is_div(i_op) ? w_a_mag : w_b_mag};
            r_opnd   <= op_is_div(i_op) ? w_b_mag : w_a_mag;
`else
            r_acc    <= {32'd0, w_b_mag};
            r_opnd   <= w_a_mag;
`endif
        end else if (i_step) begin
`ifdef MDU_DIV_EN
            if (r_is_div)
                r_acc <= w_ge ? {w_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
            else
                r_acc <= {w_sum, r_acc[31:1]};
`else
            r_acc <= {w_sum, r_acc[31:1]};
`endif
        end
    end

    always_comb begin
        {o_hi, o_lo} = w_prod_fix;
`ifdef MDU_DIV_EN
        if (r_is_div) begin
            o_lo = r_divz   ? MDU_DIVZ_LO :
                   r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
            o_hi = r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// =============================================================================
// Module      : mult_div_unit
// Description : MIPS HI/LO multiply/divide unit: FSM, counter, HI/LO, MTHI/MTLO.
//               Define MDU_DIV_EN to include the divider.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int ITER = MDU_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        WriteHi,
    input  logic        WriteLo,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam logic [5:0] c_last = 6'(ITER - 1);

    mdu_state_t  r_state;
    mdu_state_t  w_state_nxt;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] w_core_hi;
    logic [31:0] w_core_lo;
    logic        w_accept;
    logic        w_load;

    assign w_accept = Start && ((r_state == IDLE) || (r_state == DONE));
`ifdef MDU_DIV_EN
    assign w_load   = w_accept;
`else
    assign w_load   = w_accept && !op_is_div(Op);
`endif

    assign Busy = (r_state == RUN) || (r_state == FIX);
    assign Done = (r_state == DONE);
    assign Hi   = r_hi;
    assign Lo   = r_lo;

    mdu_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (r_state == RUN),
        .i_op   (Op),
        .i_opa  (OpA),
        .i_opb  (OpB),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (Start) begin
`ifdef MDU_DIV_EN
                    w_state_nxt = RUN;
`else
                    // Without a divider, DIV/DIVU just acknowledge with a Done pulse.
                    w_state_nxt = op_is_div(Op) ? DONE : RUN;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN:     if (r_cnt == c_last) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= '0;
        else if ((r_state == RUN) && (r_cnt != c_last))
            r_cnt <= r_cnt + 6'd1;
    end

    // A sampled Start takes priority over MTHI/MTLO in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == FIX) begin
            r_hi <= w_core_hi;
            r_lo <= w_core_lo;
        end else if (!Busy && !Start) begin
            if (WriteHi) r_hi <= WriteData;
            if (WriteLo) r_lo <= WriteData;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// =============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit (either build).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        WriteHi;
    logic        WriteLo;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_checks = 0;
    int n_fails  = 0;

    mult_div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Op        (Op),
        .OpA       (OpA),
        .OpB       (OpB),
        .WriteHi   (WriteHi),
        .WriteLo   (WriteLo),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches an op and ends in cycle 34 (DONE) after checking the result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        logic all_busy;
        logic any_done;
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        tick();
        Start = 1'b0;
        all_busy = 1'b1;
        any_done = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (!Busy) all_busy = 1'b0;
            if (Done)  any_done = 1'b1;
            tick();
        end
        check({tag, "_busy_1_33"}, 32'(all_busy), 32'd1);
        check({tag, "_no_early_done"}, 32'(any_done), 32'd0);
        check({tag, "_done_34"}, 32'(Done), 32'd1);
        check({tag, "_busy_34"}, 32'(Busy), 32'd0);
        check({tag, "_hi"}, Hi, exp_hi);
        check({tag, "_lo"}, Lo, exp_lo);
    endtask

    initial begin
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        rst_n = 1'b0; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0;
        WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0;
        tick();
        tick();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();
        check("idle_after_done", 32'(Done), 32'd0);

`ifdef MDU_DIV_EN
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_negb", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
        tick();
`else
        hold_hi = Hi;
        hold_lo = Lo;
        Start = 1'b1; Op = 2'b10; OpA = 32'hFFFF_FFF9; OpB = 32'h2;
        tick();
        Start = 1'b0;
        check("nodiv_busy", 32'(Busy), 32'd0);
        check("nodiv_done", 32'(Done), 32'd1);
        check("nodiv_hi", Hi, hold_hi);
        check("nodiv_lo", Lo, hold_lo);
        tick();
        check("nodiv_done_clr", 32'(Done), 32'd0);
        run_op("mult_after_nodiv", 2'b00, 32'h0000_0003, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();
`endif

        // Asynchronous abort in cycle 10 of a MULT.
        Start = 1'b1; Op = 2'b00; OpA = 32'h0001_0000; OpB = 32'h0001_0000;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("abort_busy_before", 32'(Busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_hi", Hi, 32'd0);
        check("abort_lo", Lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("abort_stays_idle", 32'(Busy), 32'd0);

        // MTHI/MTLO while idle.
        WriteLo = 1'b1; WriteData = 32'h0000_1234;
        tick();
        WriteLo = 1'b0;
        check("mtlo_idle", Lo, 32'h0000_1234);
        check("mtlo_hi_untouched", Hi, 32'd0);
        WriteHi = 1'b1; WriteData = 32'h0000_ABCD;
        tick();
        WriteHi = 1'b0;
        check("mthi_idle", Hi, 32'h0000_ABCD);
        WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'h0000_0055;
        tick();
        WriteHi = 1'b0; WriteLo = 1'b0;
        check("mthilo_hi", Hi, 32'h0000_0055);
        check("mthilo_lo", Lo, 32'h0000_0055);

        // Start wins over MTLO; stray Start and busy MTLO are dropped.
        Start = 1'b1; Op = 2'b01; OpA = 32'd5; OpB = 32'd6;
        WriteLo = 1'b1; WriteData = 32'h0000_7777;
        tick();
        Start = 1'b0; WriteLo = 1'b0;
        check("start_wins_lo", Lo, 32'h0000_0055);
        for (int c = 1; c < 5; c++) tick();
        Start = 1'b1; OpA = 32'd7; OpB = 32'd7;
        tick();
        Start = 1'b0;
        tick();
        tick();
        WriteLo = 1'b1; WriteData = 32'h0000_1234;
        tick();
        WriteLo = 1'b0;
        check("mtlo_busy_dropped", Lo, 32'h0000_0055);
        for (int c = 9; c < 34; c++) tick();
        check("stray_done", 32'(Done), 32'd1);
        check("stray_hi", Hi, 32'd0);
        check("stray_lo", Lo, 32'd30);
        tick();
        check("stray_idle_busy", 32'(Busy), 32'd0);
        check("stray_idle_done", 32'(Done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
